// File: rtl/prng_seq_ctrl.sv
// Sequencer for an LFSR random-word source: seed load, warm-up, rate-paced stepping and consumer handshake.
// Optional macro PRNG_SEQ_STATS_EN adds o_tick_cnt, a free-running count of ticks seen while running.
module prng_seq_ctrl #(
  parameter int WARMUP_STEPS = 16,
  parameter int BURST_LEN    = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_seed_valid,
  input  logic        i_stop,
  input  logic        i_tick,
  input  logic        i_ready,
  output logic        o_lfsr_load,
  output logic        o_lfsr_step,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_overrun,
  output logic [15:0] o_word_cnt
`ifdef PRNG_SEQ_STATS_EN
  ,
  output logic [31:0] o_tick_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam int WCW = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_STEPS - 1);
  localparam logic [15:0]    BURST_W   = 16'(BURST_LEN);

  state_t         state, state_n;
  logic [WCW-1:0] warm_cnt, warm_n;
  logic           load_n, step_n, valid_n, ovr_n, busy_n;
  logic [15:0]    cnt_n;
  logic           accept, pend_now, pend_after;

  // A word is pending from its step strobe until it is accepted.
  assign accept     = o_valid & i_ready;
  assign pend_now   = o_lfsr_step | o_valid;
  assign pend_after = o_lfsr_step | (o_valid & ~i_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      warm_cnt    <= '0;
      o_lfsr_load <= 1'b0;
      o_lfsr_step <= 1'b0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
      o_word_cnt  <= '0;
    end else begin
      state       <= state_n;
      warm_cnt    <= warm_n;
      o_lfsr_load <= load_n;
      o_lfsr_step <= step_n;
      o_valid     <= valid_n;
      o_busy      <= busy_n;
      o_overrun   <= ovr_n;
      o_word_cnt  <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    warm_n  = warm_cnt;
    load_n  = 1'b0;
    step_n  = 1'b0;
    valid_n = 1'b0;
    ovr_n   = 1'b0;
    cnt_n   = o_word_cnt;
    unique case (state)
      S_IDLE: begin
        if (i_start && i_seed_valid) begin
          state_n = S_LOAD;
          load_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      S_LOAD: begin
        if (i_stop) begin
          state_n = S_IDLE;
        end else if (WARMUP_STEPS == 0) begin
          state_n = S_RUN;
        end else begin
          state_n = S_WARM;
          step_n  = 1'b1;
          warm_n  = WARM_LAST;
        end
      end
      S_WARM: begin
        // warm_cnt holds the number of warm-up steps still to issue after this one
        if (i_stop) begin
          state_n = S_IDLE;
        end else if (warm_cnt == '0) begin
          state_n = S_RUN;
        end else begin
          step_n = 1'b1;
          warm_n = warm_cnt - 1'b1;
        end
      end
      S_RUN, S_DRAIN: begin
        valid_n = pend_after;
        if (accept && o_word_cnt != 16'hFFFF)
          cnt_n = o_word_cnt + 16'd1;
        if (state == S_DRAIN) begin
          if (!pend_after)
            state_n = S_IDLE;
        end else if (BURST_LEN > 0 && accept && cnt_n == BURST_W) begin
          state_n = S_IDLE;
        end else if (i_stop) begin
          state_n = pend_after ? S_DRAIN : S_IDLE;
        end else if (i_tick) begin
          if (pend_now) ovr_n  = 1'b1;
          else          step_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

`ifdef PRNG_SEQ_STATS_EN
  logic [31:0] tick_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      tick_cnt <= '0;
    else if (i_tick && (state == S_RUN || state == S_DRAIN))
      tick_cnt <= tick_cnt + 32'd1;
  end

  assign o_tick_cnt = tick_cnt;
`endif

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// Bench for prng_seq_ctrl: two instances (warm-up 4/free-running and warm-up 16/burst 3) on shared stimulus,
// checked every cycle against a behavioural model plus literal expectations per scenario.
module tb_prng_seq_ctrl;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_rst = 1'b1, i_start = 1'b0, i_seed_valid = 1'b0, i_stop = 1'b0, i_tick = 1'b0, i_ready = 1'b0;
  logic [1:0] load, step, valid, busy, ovr;
  logic [1:0][15:0] wcnt;
`ifdef PRNG_SEQ_STATS_EN
  logic [1:0][31:0] tcnt;
`endif

  prng_seq_ctrl #(.WARMUP_STEPS(4), .BURST_LEN(0)) u_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_seed_valid(i_seed_valid),
    .i_stop(i_stop), .i_tick(i_tick), .i_ready(i_ready),
    .o_lfsr_load(load[0]), .o_lfsr_step(step[0]), .o_valid(valid[0]), .o_busy(busy[0]),
    .o_overrun(ovr[0]), .o_word_cnt(wcnt[0])
`ifdef PRNG_SEQ_STATS_EN
    , .o_tick_cnt(tcnt[0])
`endif
  );

  prng_seq_ctrl #(.WARMUP_STEPS(16), .BURST_LEN(3)) u_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_seed_valid(i_seed_valid),
    .i_stop(i_stop), .i_tick(i_tick), .i_ready(i_ready),
    .o_lfsr_load(load[1]), .o_lfsr_step(step[1]), .o_valid(valid[1]), .o_busy(busy[1]),
    .o_overrun(ovr[1]), .o_word_cnt(wcnt[1])
`ifdef PRNG_SEQ_STATS_EN
    , .o_tick_cnt(tcnt[1])
`endif
  );

  // Model: mode 0 idle, 1 seeding, 2 warming, 3 running, 4 draining.
  // pend 0 none, 1 word being stepped, 2 word offered to consumer.
  typedef struct {
    int        mode;
    int        warm;
    int        pend;
    int        words;
    bit        ovr;
    bit [31:0] ticks;
  } mdl_t;

  mdl_t m[2];
  int   cfg_w[2] = '{4, 16};
  int   cfg_b[2] = '{0, 3};

  function automatic mdl_t advance(mdl_t s, int w, int b);
    mdl_t n = s;
    bit acc;
    n.ovr = 1'b0;
    if (i_rst) begin
      n.mode = 0; n.warm = 0; n.pend = 0; n.words = 0; n.ticks = '0;
      return n;
    end
    if ((s.mode == 3 || s.mode == 4) && i_tick) n.ticks = s.ticks + 32'd1;
    case (s.mode)
      0: if (i_start && i_seed_valid) begin n.mode = 1; n.words = 0; end
      1: if (i_stop) n.mode = 0;
         else if (w == 0) n.mode = 3;
         else begin n.mode = 2; n.warm = 1; end
      2: if (i_stop) n.mode = 0;
         else if (s.warm == w) n.mode = 3;
         else n.warm = s.warm + 1;
      default: begin
        acc = (s.pend == 2) && i_ready;
        if (s.pend == 1) n.pend = 2;
        else if (acc) n.pend = 0;
        if (acc && s.words < 65535) n.words = s.words + 1;
        if (s.mode == 4) begin
          if (n.pend == 0) n.mode = 0;
        end else if (acc && b > 0 && n.words == b) n.mode = 0;
        else if (i_stop) n.mode = (n.pend != 0) ? 4 : 0;
        else if (i_tick) begin
          if (s.pend != 0) n.ovr = 1'b1;
          else n.pend = 1;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge i_clk)
    for (int i = 0; i < 2; i++) m[i] = advance(m[i], cfg_w[i], cfg_b[i]);

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int n_step[2] = '{0, 0}, n_load[2] = '{0, 0}, n_valid[2] = '{0, 0}, n_ovr[2] = '{0, 0}, n_acc[2] = '{0, 0};
  int b_step[2], b_load[2], b_valid[2], b_ovr[2], b_acc[2];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h want %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("load",    i, 32'(load[i]),  32'(m[i].mode == 1));
      chk("step",    i, 32'(step[i]),  32'(m[i].mode == 2 || m[i].pend == 1));
      chk("valid",   i, 32'(valid[i]), 32'(m[i].pend == 2));
      chk("busy",    i, 32'(busy[i]),  32'(m[i].mode != 0));
      chk("overrun", i, 32'(ovr[i]),   32'(m[i].ovr));
      chk("wcnt",    i, 32'(wcnt[i]),  32'(m[i].words));
`ifdef PRNG_SEQ_STATS_EN
      chk("tcnt",    i, tcnt[i],       m[i].ticks);
`endif
    end
  endtask

  // Each cycle: compare and tally at the falling edge, then drive inputs just after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge i_clk);
      if (chk_en) compare_all();
      for (int i = 0; i < 2; i++) begin
        if (step[i] === 1'b1)  n_step[i]++;
        if (load[i] === 1'b1)  n_load[i]++;
        if (valid[i] === 1'b1) n_valid[i]++;
        if (ovr[i] === 1'b1)   n_ovr[i]++;
        if (valid[i] === 1'b1 && i_ready) n_acc[i]++;
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic mark();
    b_step = n_step; b_load = n_load; b_valid = n_valid; b_ovr = n_ovr; b_acc = n_acc;
  endtask

  task automatic start_run();
    i_start = 1'b1; i_seed_valid = 1'b1;
    cyc(1);
    i_start = 1'b0; i_seed_valid = 1'b0;
  endtask

  initial begin
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_wcnt", 1, 32'(wcnt[1]), 32'd0);
    i_rst = 1'b0;

    // start without seed is ignored
    i_start = 1'b1;
    cyc(3);
    chk("noseed_busy", 0, 32'(busy[0]), 32'd0);
    i_start = 1'b0;

    // seed load and warm-up
    mark();
    start_run();
    cyc(24);
    chk("warm_loads", 0, 32'(n_load[0] - b_load[0]), 32'd1);
    chk("warm_steps", 0, 32'(n_step[0] - b_step[0]), 32'd4);
    chk("warm_valid", 0, 32'(n_valid[0] - b_valid[0]), 32'd0);
    chk("warm_steps", 1, 32'(n_step[1] - b_step[1]), 32'd16);
    chk("run_busy",   0, 32'(busy[0]), 32'd1);

    // ready high, five spaced ticks; burst instance stops after three
    i_ready = 1'b1;
    mark();
    repeat (5) begin
      i_tick = 1'b1; cyc(1); i_tick = 1'b0; cyc(3);
    end
    cyc(2);
    chk("t5_steps", 0, 32'(n_step[0] - b_step[0]), 32'd5);
    chk("t5_wcnt",  0, 32'(wcnt[0]), 32'd5);
    chk("t5_ovr",   0, 32'(n_ovr[0] - b_ovr[0]), 32'd0);
    chk("burst_acc",  1, 32'(n_acc[1] - b_acc[1]), 32'd3);
    chk("burst_busy", 1, 32'(busy[1]), 32'd0);

    // ready low, three ticks: one step, two overruns
    i_ready = 1'b0;
    mark();
    repeat (3) begin
      i_tick = 1'b1; cyc(1); i_tick = 1'b0; cyc(2);
    end
    chk("hold_steps", 0, 32'(n_step[0] - b_step[0]), 32'd1);
    chk("hold_ovr",   0, 32'(n_ovr[0] - b_ovr[0]), 32'd2);
    chk("hold_valid", 0, 32'(valid[0]), 32'd1);
    i_ready = 1'b1;
    cyc(2);
    chk("hold_wcnt",  0, 32'(wcnt[0]), 32'd6);
    chk("hold_vdrop", 0, 32'(valid[0]), 32'd0);
    i_ready = 1'b0;

    // stop with same-cycle tick while a word is pending -> drain
    i_tick = 1'b1; cyc(1); i_tick = 1'b0; cyc(2);
    mark();
    i_stop = 1'b1; i_tick = 1'b1; cyc(1); i_stop = 1'b0; i_tick = 1'b0;
    cyc(3);
    chk("drain_busy",  0, 32'(busy[0]), 32'd1);
    chk("drain_valid", 0, 32'(valid[0]), 32'd1);
    chk("drain_steps", 0, 32'(n_step[0] - b_step[0]), 32'd0);
    i_ready = 1'b1;
    cyc(2);
    chk("drain_idle", 0, 32'(busy[0]), 32'd0);
    chk("drain_wcnt", 0, 32'(wcnt[0]), 32'd7);
    i_ready = 1'b0;

    // reset during warm-up step 2
    start_run();
    cyc(2);
    chk("warm2_step", 1, 32'(step[1]), 32'd1);
    i_rst = 1'b1; cyc(1); i_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("mrst_step", i, 32'(step[i]), 32'd0);
      chk("mrst_busy", i, 32'(busy[i]), 32'd0);
      chk("mrst_wcnt", i, 32'(wcnt[i]), 32'd0);
    end
    i_start = 1'b1; cyc(4); i_start = 1'b0;
    chk("mrst_noseed", 1, 32'(busy[1]), 32'd0);

    // stop during warm-up aborts
    start_run();
    cyc(2);
    i_stop = 1'b1; cyc(1); i_stop = 1'b0;
    chk("abort_busy", 1, 32'(busy[1]), 32'd0);
    chk("abort_step", 1, 32'(step[1]), 32'd0);

    // continuous ticks and ready: burst of three
    start_run();
    cyc(20);
    i_ready = 1'b1; i_tick = 1'b1;
    mark();
    cyc(20);
    chk("cont_acc",  1, 32'(n_acc[1] - b_acc[1]), 32'd3);
    chk("cont_wcnt", 1, 32'(wcnt[1]), 32'd3);
    chk("cont_busy", 1, 32'(busy[1]), 32'd0);
    i_tick = 1'b0;
    i_stop = 1'b1; cyc(1); i_stop = 1'b0;
    cyc(3);
    i_ready = 1'b0;
    cyc(2);
    chk("end_busy", 0, 32'(busy[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
